// File: rtl/kernel3_gmem_c_s_axi_write_responder_pkg.sv
// Shared AXI write-responder definitions for the gmem_C port:
// response codes, FSM state type and beat-size helper.
package kernel3_gmem_c_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } wr_state_e;

    function automatic int beat_bytes(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/kernel3_gmem_c_s_axi_write_responder_if.sv
// AXI4 write-channel bundle (AW, W, B) between the gmem_C master
// and the write responder.
interface kernel3_gmem_c_s_axi_write_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1
) ();

    logic [ADDR_WIDTH-1:0]   s_awaddr;
    logic [7:0]              s_awlen;
    logic [ID_WIDTH-1:0]     s_awid;
    logic                    s_awvalid;
    logic                    s_awready;
    logic [DATA_WIDTH-1:0]   s_wdata;
    logic [DATA_WIDTH/8-1:0] s_wstrb;
    logic                    s_wlast;
    logic                    s_wvalid;
    logic                    s_wready;
    logic [1:0]              s_bresp;
    logic [ID_WIDTH-1:0]     s_bid;
    logic                    s_bvalid;
    logic                    s_bready;

    modport master (
        output s_awaddr, s_awlen, s_awid, s_awvalid,
        output s_wdata, s_wstrb, s_wlast, s_wvalid,
        output s_bready,
        input  s_awready, s_wready,
        input  s_bresp, s_bid, s_bvalid
    );

    modport slave (
        input  s_awaddr, s_awlen, s_awid, s_awvalid,
        input  s_wdata, s_wstrb, s_wlast, s_wvalid,
        input  s_bready,
        output s_awready, s_wready,
        output s_bresp, s_bid, s_bvalid
    );

endinterface

// File: rtl/kernel3_gmem_c_s_axi_write_responder.sv
// AXI4 write responder for gmem_C: splits INCR bursts into single-word memory writes.
// Define KERNEL3_GMEM_C_WR_BOUNDARY_CHK_EN to drop beats at or above MEM_BYTES and answer DECERR.
module kernel3_gmem_c_s_axi_write_responder
    import kernel3_gmem_c_axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1,
    parameter int MEM_BYTES  = 65536
) (
    input  logic                                     clk,
    input  logic                                     reset,
    kernel3_gmem_c_s_axi_write_responder_if.slave    s_axi,
    output logic                                     mem_we,
    output logic [ADDR_WIDTH-1:0]                    mem_addr,
    output logic [DATA_WIDTH-1:0]                    mem_wdata,
    output logic [DATA_WIDTH/8-1:0]                  mem_wstrb
);

    localparam int BEAT_BYTES = beat_bytes(DATA_WIDTH);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    if (DATA_WIDTH < 8 || MEM_BYTES < 1) begin : g_bad_params
        $error("kernel3_gmem_c_s_axi_write_responder: invalid DATA_WIDTH or MEM_BYTES");
    end

    wr_state_e               state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic                    err_q, err_d;
    logic                    awready_q, awready_d;
    logic                    wready_q, wready_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [ID_WIDTH-1:0]     bid_q, bid_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_WIDTH-1:0]   mem_wstrb_q, mem_wstrb_d;

    logic aw_hs, w_hs, b_hs;
    logic last_beat, err_next, beat_in_window, dec_next;

    assign aw_hs     = s_axi.s_awvalid & awready_q;
    assign w_hs      = s_axi.s_wvalid & wready_q;
    assign b_hs      = bvalid_q & s_axi.s_bready;
    assign last_beat = (cnt_q == len_q);
    // wlast only feeds the error flag; burst length always comes from awlen
    assign err_next  = err_q | (s_axi.s_wlast ^ last_beat);

`ifdef KERNEL3_GMEM_C_WR_BOUNDARY_CHK_EN
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_BYTES);

    logic dec_q, dec_d;

    assign beat_in_window = ({1'b0, addr_q} < MEM_LIMIT);
    assign dec_next       = dec_q | ~beat_in_window;

    always_comb begin
        dec_d = dec_q;
        if (state_q == IDLE && aw_hs) begin
            dec_d = 1'b0;
        end else if (state_q == DATA && w_hs) begin
            dec_d = dec_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_q <= 1'b0;
        end else begin
            dec_q <= dec_d;
        end
    end
`else
    assign beat_in_window = 1'b1;
    assign dec_next       = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        err_d       = err_q;
        bresp_d     = bresp_q;
        bid_d       = bid_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;

        case (state_q)
            IDLE: begin
                if (aw_hs) begin
                    addr_d  = s_axi.s_awaddr;
                    len_d   = s_axi.s_awlen;
                    id_d    = s_axi.s_awid;
                    cnt_d   = 8'd0;
                    err_d   = 1'b0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (w_hs) begin
                    mem_we_d    = beat_in_window;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = s_axi.s_wdata;
                    mem_wstrb_d = s_axi.s_wstrb;
                    addr_d      = addr_q + ADDR_WIDTH'(BEAT_BYTES);
                    cnt_d       = cnt_q + 8'd1;
                    err_d       = err_next;
                    if (last_beat) begin
                        state_d = RESP;
                        bid_d   = id_q;
                        bresp_d = dec_next ? RESP_DECERR :
                                  err_next ? RESP_SLVERR : RESP_OKAY;
                    end
                end
            end
            RESP: begin
                if (b_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Ready/valid are registered from the next state so they change on the handshake edge
        awready_d = (state_d == IDLE);
        wready_d  = (state_d == DATA);
        bvalid_d  = (state_d == RESP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            id_q        <= '0;
            err_q       <= 1'b0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= '0;
            bid_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            err_q       <= err_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            bid_q       <= bid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    assign s_axi.s_awready = awready_q;
    assign s_axi.s_wready  = wready_q;
    assign s_axi.s_bvalid  = bvalid_q;
    assign s_axi.s_bresp   = bresp_q;
    assign s_axi.s_bid     = bid_q;
    assign mem_we          = mem_we_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_wstrb       = mem_wstrb_q;

endmodule

// File: tb/tb_kernel3_gmem_c_s_axi_write_responder.sv
// Randomized self-checking bench for the gmem_C write responder: bursts are
// predicted from AXI rules (address list, wlast check, window check) and compared.
`timescale 1ns/1ps
module tb_kernel3_gmem_c_s_axi_write_responder;

   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;
   localparam int ID_WIDTH   = 1;
   localparam int MEM_BYTES  = 'h1000;
   localparam int TIMEOUT    = 64;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   wr_t  exp_q[$];
   int   wr_cycles[$];

   kernel3_gmem_c_s_axi_write_responder_if #(
      .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH)
   ) axi ();

   kernel3_gmem_c_s_axi_write_responder #(
      .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
      .ID_WIDTH(ID_WIDTH), .MEM_BYTES(MEM_BYTES)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .s_axi     (axi.slave),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb)
   );

   // Free-running clock, period 10
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Memory window as seen by the reference model
   function automatic bit inWindow(input logic [31:0] a);
`ifdef KERNEL3_GMEM_C_WR_BOUNDARY_CHK_EN
      return longint'(a) < longint'(MEM_BYTES);
`else
      return (a === a);
`endif
   endfunction

   // Memory-port scoreboard: every write must match the next predicted one
   always @(negedge clk) begin : mem_monitor
      wr_t e;
      cyc++;
      if (mem_we === 1'b1) begin
         wr_cycles.push_back(cyc);
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_write", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            checkOutput("mem_addr", mem_addr, e.addr);
            checkOutput("mem_wdata", mem_wdata, e.data);
            checkOutput("mem_wstrb", mem_wstrb, e.strb);
         end
      end
   end

   // Present AW at a falling edge and hold until the handshake edge has passed
   task automatic sendAw(input logic [31:0] a, input int len, input logic id);
      int w;
      axi.s_awaddr  = a;
      axi.s_awlen   = 8'(len);
      axi.s_awid    = id;
      axi.s_awvalid = 1'b1;
      w = 0;
      while (axi.s_awready !== 1'b1 && w < TIMEOUT) begin
         @(negedge clk);
         w++;
      end
      if (w >= TIMEOUT) checkOutput("aw_timeout", 0, 1);
      @(negedge clk);
      axi.s_awvalid = 1'b0;
   endtask

   // Present one W beat and return at the falling edge after it was taken
   task automatic sendBeat(input logic [31:0] d, input logic [3:0] s, input logic last);
      int w;
      axi.s_wvalid = 1'b1;
      axi.s_wdata  = d;
      axi.s_wstrb  = s;
      axi.s_wlast  = last;
      w = 0;
      while (axi.s_wready !== 1'b1 && w < TIMEOUT) begin
         @(negedge clk);
         w++;
      end
      if (w >= TIMEOUT) checkOutput("w_timeout", 0, 1);
      @(negedge clk);
   endtask

   // wl_mode: 0 correct wlast, 1 early wlast on beat 1, 2 no wlast on final beat, 3 early wlast on a random beat
   task automatic applyStimulus(input logic [31:0] start, input int len, input logic id,
                                input int wl_mode, input int bdelay, input bit gaps,
                                input bit pre_w, input bit rand_data);
      logic        wl  [0:255];
      logic [31:0] dat [0:255];
      logic [3:0]  stb [0:255];
      logic [31:0] a;
      logic [1:0]  exp_resp;
      bit          exp_err, exp_dec;
      int          nexp, n;

      exp_err = 0;
      exp_dec = 0;
      nexp    = 0;
      for (int i = 0; i <= len; i++) begin
         wl[i]  = (i == len);
         dat[i] = rand_data ? $urandom : 32'hDEADBEEF + i;
         stb[i] = rand_data ? 4'($urandom_range(1, 15)) : 4'hF;
      end
      if (wl_mode == 1 && len > 0) wl[(len > 1) ? 1 : 0] = 1'b1;
      else if (wl_mode == 2) wl[len] = 1'b0;
      else if (wl_mode == 3 && len > 0) wl[$urandom_range(0, len - 1)] = 1'b1;

      for (int i = 0; i <= len; i++) begin
         a = start + 32'(i * 4);
         if (wl[i] != (i == len)) exp_err = 1;
         if (inWindow(a)) begin
            exp_q.push_back('{a, dat[i], stb[i]});
            nexp++;
         end else begin
            exp_dec = 1;
         end
      end
      exp_resp = exp_dec ? 2'b11 : (exp_err ? 2'b10 : 2'b00);

      wr_cycles.delete();
      axi.s_bready = (bdelay == 0);
      if (pre_w) begin
         axi.s_wvalid = 1'b1;
         axi.s_wdata  = dat[0];
         axi.s_wstrb  = stb[0];
         axi.s_wlast  = wl[0];
         repeat (5) begin
            @(negedge clk);
            checkOutput("idle_wready", axi.s_wready, 0);
            checkOutput("idle_mem_we", mem_we, 0);
         end
      end

      fork
         sendAw(start, len, id);
         begin
            for (int i = 0; i <= len; i++) begin
               if (gaps && i > 0 && $urandom_range(0, 2) == 0) begin
                  axi.s_wvalid = 1'b0;
                  @(negedge clk);
               end
               sendBeat(dat[i], stb[i], wl[i]);
            end
            axi.s_wvalid = 1'b0;
         end
      join

      n = 0;
      while (axi.s_bvalid !== 1'b1 && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      checkOutput("b_valid", axi.s_bvalid, 1);
      checkOutput("b_id", axi.s_bid, id);
      checkOutput("b_resp", axi.s_bresp, exp_resp);
      checkOutput("aw_ready_in_resp", axi.s_awready, 0);
      for (int c = 0; c < bdelay; c++) begin
         @(negedge clk);
         checkOutput("b_hold", axi.s_bvalid, 1);
      end
      axi.s_bready = 1'b1;
      @(negedge clk);
      checkOutput("b_drop", axi.s_bvalid, 0);
      checkOutput("aw_ready_idle", axi.s_awready, 1);
      axi.s_bready = 1'b0;

      checkOutput("writes_left", exp_q.size(), 0);
      checkOutput("write_count", wr_cycles.size(), nexp);
      if (!gaps && nexp == len + 1 && wr_cycles.size() > 0)
         checkOutput("burst_span", wr_cycles[$] - wr_cycles[0], len);
   endtask

   // Abort an 8-beat burst after three beats by asserting reset
   task automatic applyResetMidBurst();
      wr_cycles.delete();
      for (int i = 0; i < 3; i++)
         exp_q.push_back('{32'h300 + 32'(i * 4), 32'hA5A50000 + i, 4'hF});
      fork
         sendAw(32'h300, 7, 1'b0);
         for (int i = 0; i < 3; i++) sendBeat(32'hA5A50000 + i, 4'hF, 1'b0);
      join
      axi.s_wdata = 32'h5555_5555;
      #2 reset = 1'b1;
      #1;
      checkOutput("rst_mem_we", mem_we, 0);
      checkOutput("rst_bvalid", axi.s_bvalid, 0);
      checkOutput("rst_wready", axi.s_wready, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      axi.s_wvalid = 1'b0;
      @(negedge clk);
      checkOutput("rst_aw_ready", axi.s_awready, 1);
      checkOutput("rst_no_b", axi.s_bvalid, 0);
      repeat (3) @(negedge clk);
      checkOutput("rst_writes_left", exp_q.size(), 0);
      checkOutput("rst_write_count", wr_cycles.size(), 3);
   endtask

   initial begin
      int rlen, rmode, rdel;
      logic [31:0] raddr;
      reset          = 1'b1;
      axi.s_awaddr   = '0;
      axi.s_awlen    = '0;
      axi.s_awid     = '0;
      axi.s_awvalid  = 1'b0;
      axi.s_wdata    = '0;
      axi.s_wstrb    = '0;
      axi.s_wlast    = 1'b0;
      axi.s_wvalid   = 1'b0;
      axi.s_bready   = 1'b0;

      repeat (3) @(negedge clk);
      checkOutput("reset_awready", axi.s_awready, 0);
      checkOutput("reset_wready", axi.s_wready, 0);
      checkOutput("reset_bvalid", axi.s_bvalid, 0);
      checkOutput("reset_bresp", axi.s_bresp, 0);
      checkOutput("reset_bid", axi.s_bid, 0);
      checkOutput("reset_mem_we", mem_we, 0);
      checkOutput("reset_mem_addr", mem_addr, 0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("first_awready", axi.s_awready, 1);
      checkOutput("first_wready", axi.s_wready, 0);

      applyStimulus(32'h100, 0, 1'b1, 0, 0, 0, 0, 0);
      applyStimulus(32'h200, 3, 1'b0, 0, 3, 0, 0, 0);
      applyStimulus(32'h240, 3, 1'b1, 1, 1, 0, 0, 1);
      applyStimulus(32'h400, 2, 1'b0, 0, 0, 0, 1, 1);
      applyResetMidBurst();
      applyStimulus(32'h500, 1, 1'b1, 0, 0, 0, 0, 1);
      applyStimulus(32'h000, 0, 1'b0, 2, 1, 0, 0, 1);
      applyStimulus(32'hFFFF_FFF8, 3, 1'b1, 0, 0, 0, 0, 1);
      applyStimulus(32'h0000_0FF8, 3, 1'b0, 0, 2, 0, 0, 1);

      for (int t = 0; t < 30; t++) begin
         raddr = 32'($urandom_range(0, 'h1400)) & 32'hFFFF_FFFC;
         rlen  = $urandom_range(0, 7);
         rmode = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         rdel  = $urandom_range(0, 3);
         applyStimulus(raddr, rlen, 1'($urandom_range(0, 1)), rmode, rdel,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0), 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop if the stimulus ever stalls
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
